// File: rtl/ksz_rx_frame_reader_if.sv
// ksz_rx_frame_reader_if: KSZ8851 host bus pins plus the delivered RX word stream
interface ksz_rx_frame_reader_if;
  logic CMD, RDN, WRN;
  logic [15:0] SD;
  logic [15:0] rxData;
  logic rxValid, rxSof, rxEof, rxErr;
  logic [11:0] rxLen;
  modport master (output CMD, RDN, WRN, rxData, rxValid, rxSof, rxEof, rxErr, rxLen, input SD);
  modport slave (input CMD, RDN, WRN, rxData, rxValid, rxSof, rxEof, rxErr, rxLen, output SD);
endinterface

// File: rtl/ksz_rx_frame_reader.sv
// ksz_rx_frame_reader: polls the KSZ8851 ISR and DMA-reads every queued RX frame into a word stream
module ksz_rx_frame_reader #(
  parameter int POLL_DIV = 4000,
  parameter int MAX_LEN = 1522
) (
  input  logic clk40m,
  input  logic reset,
  input  logic initDone,
  output wire [15:0] SDReg,
  output logic busy,
  ksz_rx_frame_reader_if.master bus
);
  localparam int PW = $clog2(POLL_DIV + 1);
  typedef enum logic [3:0] {
    IDLE, POLL_WAIT, RD_ISR, CLR_ISR, RD_FCTR, RD_FHSR, RD_FHBCR,
    SDA_ON, DMA_HDR, DMA_DATA, SDA_OFF, DROP, DROP_POLL, NEXT
  } state_t;
  typedef struct packed {
    state_t state;
    logic [2:0] stg;
    logic [PW-1:0] pcnt;
    logic [7:0] frm_cnt;
    logic [15:0] status;
    logic [10:0] wcnt;
    logic [1:0] hcnt;
    logic sof_pend, busy, cmd, rdn, wrn, oe;
    logic [15:0] sdo, rx_data;
    logic rx_valid, rx_sof, rx_eof, rx_err;
    logic [11:0] rx_len;
  } regs_t;
  regs_t r, n;
  logic is_wr, is_rd, is_dma, fin, dfin, bad;
  logic [7:0] addr;
  logic [15:0] cmd_word, wdata;
  logic [11:0] len_sd;
  logic [12:0] nwords;
  assign is_wr = r.state inside {CLR_ISR, SDA_ON, SDA_OFF, DROP};
  assign is_rd = r.state inside {RD_ISR, RD_FCTR, RD_FHSR, RD_FHBCR, DROP_POLL};
  assign is_dma = r.state inside {DMA_HDR, DMA_DATA};
  assign fin = (is_wr || is_rd) && r.stg == 3'd5;
  assign dfin = is_dma && r.stg == 3'd3;
  assign addr = r.state inside {RD_ISR, CLR_ISR} ? 8'h92 : r.state == RD_FCTR ? 8'h9C :
                r.state == RD_FHSR ? 8'h7C : r.state == RD_FHBCR ? 8'h7E : 8'h82;
  assign wdata = r.state == CLR_ISR ? 16'h2000 : r.state == SDA_ON ? 16'h0238 :
                 r.state == SDA_OFF ? 16'h0230 : 16'h0231;
  assign cmd_word = {addr[1] ? 4'hC : 4'h3, 4'h0, addr};
  assign len_sd = bus.SD[11:0];
  // words are fetched in 32-bit pairs, so round the byte count up to a dword
  assign nwords = ((13'({1'b0, len_sd}) + 13'd3) >> 2) << 1;
  assign bad = !r.status[15] || (r.status & 16'h3C17) != 16'h0 || len_sd == 12'd0 || int'(len_sd) > MAX_LEN;
  assign SDReg = r.oe ? r.sdo : 16'hz;
  assign busy = r.busy;
  assign bus.CMD = r.cmd;
  assign bus.RDN = r.rdn;
  assign bus.WRN = r.wrn;
  assign bus.rxData = r.rx_data;
  assign bus.rxValid = r.rx_valid;
  assign bus.rxSof = r.rx_sof;
  assign bus.rxEof = r.rx_eof;
  assign bus.rxErr = r.rx_err;
  assign bus.rxLen = r.rx_len;
  always_comb begin
    n = r;
    n.rx_valid = 1'b0;
    n.rx_sof = 1'b0;
    n.rx_eof = 1'b0;
    n.rx_err = 1'b0;
    if (is_wr || is_rd) begin
      n.stg = fin ? 3'd0 : r.stg + 3'd1;
      if (r.stg == 3'd0) begin
        n.cmd = 1'b1;
        n.wrn = 1'b0;
        n.oe = 1'b1;
        n.sdo = cmd_word;
      end
      if (r.stg == 3'd2) n.wrn = 1'b1;
      if (r.stg == 3'd3) begin
        n.cmd = 1'b0;
        n.wrn = !is_wr;
        n.rdn = is_wr;
        n.oe = is_wr;
        n.sdo = wdata;
      end
      if (fin) begin
        n.wrn = 1'b1;
        n.rdn = 1'b1;
        n.oe = 1'b0;
      end
    end
    if (is_dma) begin
      n.stg = dfin ? 3'd0 : r.stg + 3'd1;
      if (r.stg == 3'd0) begin
        n.cmd = 1'b0;
        n.rdn = 1'b0;
      end
      if (r.stg == 3'd2) n.rdn = 1'b1;
      if (r.stg == 3'd2 && r.state == DMA_DATA) begin
        n.rx_data = bus.SD;
        n.rx_valid = 1'b1;
        n.rx_sof = r.sof_pend;
        n.rx_eof = r.wcnt == 11'd0;
        n.sof_pend = 1'b0;
      end
    end
    case (r.state)
      IDLE: if (initDone) begin
        n.state = POLL_WAIT;
        n.pcnt = '0;
      end
      POLL_WAIT: begin
        n.pcnt = r.pcnt + PW'(1);
        if (!initDone) n.state = IDLE;
        else if (r.pcnt == PW'(POLL_DIV - 1)) n.state = RD_ISR;
      end
      RD_ISR: if (fin) begin
        n.state = bus.SD[13] ? CLR_ISR : POLL_WAIT;
        n.busy = bus.SD[13];
        n.pcnt = '0;
      end
      CLR_ISR: if (fin) n.state = RD_FCTR;
      RD_FCTR: if (fin) begin
        n.frm_cnt = bus.SD[15:8];
        n.state = bus.SD[15:8] == 8'd0 ? POLL_WAIT : RD_FHSR;
        n.busy = bus.SD[15:8] != 8'd0;
        n.pcnt = '0;
      end
      RD_FHSR: if (fin) begin
        n.status = bus.SD;
        n.state = RD_FHBCR;
      end
      RD_FHBCR: if (fin) begin
        n.rx_len = len_sd;
        n.wcnt = 11'(nwords - 13'd1);
        n.state = bad ? DROP : SDA_ON;
      end
      SDA_ON: if (fin) begin
        n.state = DMA_HDR;
        n.hcnt = '0;
        n.sof_pend = 1'b1;
      end
      DMA_HDR: if (dfin) begin
        n.hcnt = r.hcnt + 2'd1;
        n.state = r.hcnt == 2'd2 ? DMA_DATA : DMA_HDR;
      end
      DMA_DATA: if (dfin) begin
        n.wcnt = r.wcnt - 11'd1;
        n.state = r.wcnt == 11'd0 ? SDA_OFF : DMA_DATA;
      end
      SDA_OFF: if (fin) n.state = NEXT;
      DROP: if (fin) begin
        n.rx_err = 1'b1;
        n.state = DROP_POLL;
      end
      DROP_POLL: if (fin && !bus.SD[0]) n.state = NEXT;
      NEXT: begin
        n.frm_cnt = r.frm_cnt - 8'd1;
        n.state = r.frm_cnt == 8'd1 ? POLL_WAIT : RD_FHSR;
        n.busy = r.frm_cnt != 8'd1;
        n.pcnt = '0;
      end
      default: n.state = IDLE;
    endcase
  end
  always_ff @(posedge clk40m or negedge reset)
    if (!reset) begin
      r <= '0;
      r.cmd <= 1'b1;
      r.rdn <= 1'b1;
      r.wrn <= 1'b1;
    end else r <= n;
endmodule

// File: tb/tb_ksz_rx_frame_reader.sv
// tb_ksz_rx_frame_reader: KSZ8851 bus model feeding the reader, with a scoreboard of delivered words
module tb_ksz_rx_frame_reader;
  localparam int PD = 20;
  logic clk40m = 1'b0, reset = 1'b1, initDone = 1'b0;
  wire [15:0] SDReg;
  logic busy;
  logic [15:0] sd;
  ksz_rx_frame_reader_if bus();
  ksz_rx_frame_reader #(.POLL_DIV(PD), .MAX_LEN(1522)) dut (
    .clk40m(clk40m), .reset(reset), .initDone(initDone), .SDReg(SDReg), .busy(busy), .bus(bus)
  );
  always #5 clk40m = ~clk40m;
  assign bus.SD = sd;
  typedef struct packed {logic [15:0] d; logic sof; logic eof; logic [11:0] len;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] pat(input int f, input int k);
    return 16'(f * 1000 + k + 7);
  endfunction
  logic [15:0] fctr = 16'h0;
  logic [15:0] fhsr [4];
  logic [11:0] flen [4];
  logic [7:0] addr_l = 8'h0;
  logic [15:0] wd = 16'h0;
  logic sda = 1'b0, prdn = 1'b1, pwrn = 1'b1, perr = 1'b0;
  int ev_set = 0, ev_clr = 0, dma_idx = 0, dma_f = 0, fi = 0, pend = 0, cyc = 0, last_isr = 0, isr_per = 0;
  int isr_rd = 0, clr_wr = 0, son = 0, soff = 0, drop_wr = 0, rq_rd = 0, strobes = 0;
  int rx_words = 0, err_pulses = 0, err_cyc = 0, busy_cyc = 0;
  int b_isr, b_clr, b_son, b_soff, b_drop, b_rq, b_str, b_rx, b_err, b_errc, b_busy;
  always_comb begin
    sd = 16'h0;
    if (sda) sd = dma_idx < 3 ? 16'h5A5A : pat(dma_f, dma_idx - 3);
    else case (addr_l)
      8'h92: sd = ev_set != ev_clr ? 16'h2000 : 16'h0000;
      8'h9C: sd = fctr;
      8'h7C: sd = fhsr[fi[1:0]];
      8'h7E: sd = {4'h0, flen[fi[1:0]]};
      8'h82: sd = {15'h0118, pend != 0};
      default: sd = 16'h0;
    endcase
  end
  always @(negedge clk40m) begin
    cyc++;
    if (!reset) begin
      sda = 1'b0;
      prdn = 1'b1;
      pwrn = 1'b1;
      perr = 1'b0;
    end else begin
      if (!bus.WRN) begin
        if (bus.CMD) addr_l = SDReg[7:0];
        else wd = SDReg;
      end
      if ((pwrn && !bus.WRN) || (prdn && !bus.RDN)) strobes++;
      if (!pwrn && bus.WRN && !bus.CMD) begin
        if (addr_l == 8'h92 && wd == 16'h2000) begin
          clr_wr++;
          ev_clr = ev_set;
        end
        if (addr_l == 8'h82 && wd == 16'h0238) begin
          son++;
          sda = 1'b1;
          dma_idx = 0;
          dma_f = fi - 1;
        end
        if (addr_l == 8'h82 && wd == 16'h0230) begin
          soff++;
          sda = 1'b0;
        end
        if (addr_l == 8'h82 && wd == 16'h0231) begin
          drop_wr++;
          pend = 2;
        end
      end
      if (!prdn && bus.RDN) begin
        if (sda) dma_idx++;
        else begin
          if (addr_l == 8'h92) begin
            isr_rd++;
            isr_per = cyc - last_isr;
            last_isr = cyc;
          end
          if (addr_l == 8'h9C) fi = 0;
          if (addr_l == 8'h7E) fi++;
          if (addr_l == 8'h82) begin
            rq_rd++;
            if (pend > 0) pend--;
          end
        end
      end
      prdn = bus.RDN;
      pwrn = bus.WRN;
      if (bus.rxValid) begin
        rx_words++;
        if (q.size() == 0) chk("rx_extra", {31'b0, bus.rxValid}, 32'd0);
        else begin
          e = q.pop_front();
          chk("rx_data", bus.rxData, e.d);
          chk("rx_sof", bus.rxSof, e.sof);
          chk("rx_eof", bus.rxEof, e.eof);
          chk("rx_len", bus.rxLen, e.len);
        end
      end
      if (bus.rxErr) err_cyc++;
      if (bus.rxErr && !perr) err_pulses++;
      perr = bus.rxErr;
      if (busy) busy_cyc++;
    end
  end
  task automatic run(input int n);
    repeat (n) @(negedge clk40m);
  endtask
  task automatic snap();
    b_isr = isr_rd; b_clr = clr_wr; b_son = son; b_soff = soff; b_drop = drop_wr; b_rq = rq_rd;
    b_str = strobes; b_rx = rx_words; b_err = err_pulses; b_errc = err_cyc; b_busy = busy_cyc;
  endtask
  task automatic cfg(input logic [15:0] fc, input logic [15:0] s0, input int l0, input logic [15:0] s1, input int l1);
    fctr = fc;
    fhsr[0] = s0;
    flen[0] = 12'(l0);
    fhsr[1] = s1;
    flen[1] = 12'(l1);
  endtask
  task automatic push_frame(input int f, input int len);
    int nw;
    nw = ((len + 3) >> 2) << 1;
    for (int k = 0; k < nw; k++) q.push_back('{d: pat(f, k), sof: k == 0, eof: k == nw - 1, len: 12'(len)});
  endtask
  task automatic chk_frame_done(input string tag, input int words, input int sda_pairs, input int len);
    chk({tag, "_left"}, q.size(), 0);
    chk({tag, "_words"}, rx_words - b_rx, words);
    chk({tag, "_sda_on"}, son - b_son, sda_pairs);
    chk({tag, "_sda_off"}, soff - b_soff, sda_pairs);
    chk({tag, "_isr_clr"}, clr_wr - b_clr, 1);
    chk({tag, "_rxlen"}, bus.rxLen, len);
    chk({tag, "_busy"}, busy, 0);
  endtask
  task automatic chk_drop(input string tag, input int len);
    chk({tag, "_words"}, rx_words - b_rx, 0);
    chk({tag, "_err_pulses"}, err_pulses - b_err, 1);
    chk({tag, "_err_cycles"}, err_cyc - b_errc, 1);
    chk({tag, "_rrxef_wr"}, drop_wr - b_drop, 1);
    chk({tag, "_rxqcr_polls"}, rq_rd - b_rq, 3);
    chk({tag, "_sda_on"}, son - b_son, 0);
    chk({tag, "_rxlen"}, bus.rxLen, len);
    chk({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    int i;
    cfg(16'h0, 16'h0, 0, 16'h0, 0);
    #1 reset = 1'b0;
    run(3);
    chk("rst_cmd", bus.CMD, 1);
    chk("rst_rdn", bus.RDN, 1);
    chk("rst_wrn", bus.WRN, 1);
    chk("rst_valid", bus.rxValid, 0);
    chk("rst_len", bus.rxLen, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    snap();
    run(5);
    chk("idle_no_strobes", strobes - b_str, 0);
    snap();
    initDone = 1'b1;
    run(6 * (PD + 6));
    chk("poll_reads", (isr_rd - b_isr) >= 4, 1);
    chk("poll_period", isr_per, PD + 6);
    chk("poll_no_rx", rx_words - b_rx, 0);
    chk("poll_no_busy", busy_cyc - b_busy, 0);
    chk("poll_no_clr", clr_wr - b_clr, 0);
    snap();
    cfg(16'h0100, 16'h8000, 64, 16'h0, 0);
    push_frame(0, 64);
    ev_set++;
    run(450);
    chk_frame_done("f64", 32, 1, 64);
    snap();
    cfg(16'h0200, 16'h8000, 60, 16'h8000, 61);
    push_frame(0, 60);
    push_frame(1, 61);
    ev_set++;
    run(700);
    chk_frame_done("two", 62, 2, 61);
    snap();
    cfg(16'h0100, 16'h8001, 100, 16'h0, 0);
    ev_set++;
    run(300);
    chk_drop("crc", 100);
    snap();
    cfg(16'h0100, 16'h8000, 1600, 16'h0, 0);
    ev_set++;
    run(300);
    chk_drop("oversize", 1600);
    snap();
    cfg(16'h0200, 16'h8000, 0, 16'h8000, 1522);
    push_frame(1, 1522);
    ev_set++;
    run(3700);
    chk_frame_done("max", 762, 1, 1522);
    chk("max_zero_len_err", err_pulses - b_err, 1);
    snap();
    cfg(16'h0100, 16'h8000, 64, 16'h0, 0);
    push_frame(0, 64);
    ev_set++;
    i = 0;
    while (i < 800 && rx_words - b_rx < 10) begin
      @(negedge clk40m);
      i++;
    end
    chk("rst_reach_w10", rx_words - b_rx, 10);
    #2 reset = 1'b0;
    initDone = 1'b0;
    #1;
    chk("mid_cmd", bus.CMD, 1);
    chk("mid_rdn", bus.RDN, 1);
    chk("mid_wrn", bus.WRN, 1);
    chk("mid_valid", bus.rxValid, 0);
    chk("mid_sof", bus.rxSof, 0);
    chk("mid_eof", bus.rxEof, 0);
    chk("mid_err", bus.rxErr, 0);
    chk("mid_data", bus.rxData, 0);
    chk("mid_len", bus.rxLen, 0);
    chk("mid_busy", busy, 0);
    q.delete();
    run(3);
    reset = 1'b1;
    snap();
    run(80);
    chk("post_rst_quiet", strobes - b_str, 0);
    chk("post_rst_busy", busy_cyc - b_busy, 0);
    initDone = 1'b1;
    run(60);
    chk("post_rst_polls", (isr_rd - b_isr) >= 1, 1);
    chk("post_rst_no_rx", rx_words - b_rx, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
